calc_unit_param: RTL

- Parametrised, handshaked successor to the team's fixed 4-bit calculator datapath/controller pair.
- Accepts an opcode and two WIDTH-bit unsigned operands on a start pulse.
- Executes add, subtract, load, multi-cycle barrel-free shifts, or an iterative shift-add multiply.
- Returns registered results with carry/zero/error flags and a one-cycle done strobe. Sits between switch/bus input logic and display/result consumers.

---
 rtl/calc_unit_param.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/calc_unit_param.sv
// calc_unit_param: handshaked multi-cycle calculator.
// Captures an opcode and two WIDTH-bit unsigned operands on i_start while idle.
// It runs ADD/SUB/SHL/SHR/MUL/LOAD and returns registered results and flags
// with a one-cycle o_done strobe.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   i_start      request, sampled only while idle
//   i_op         opcode (3 bits), captured with i_start
//   i_a_in       operand A
//   i_b_in       operand B / shift count
//   o_busy       high whenever the controller is not idle
//   o_done       one-cycle completion strobe
//   o_result_lo  result low word
//   o_result_hi  result high word (MUL upper half, otherwise operand B)
//   o_carry      carry / borrow / last bit shifted out
//   o_zero       full result is zero ({hi,lo} for MUL, lo otherwise)
//   o_err        last completed op was illegal
module calc_unit_param #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a_in,
    input  logic [WIDTH-1:0] i_b_in,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result_lo,
    output logic [WIDTH-1:0] o_result_hi,
    output logic             o_carry,
    output logic             o_zero,
    output logic             o_err
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned PW    = 2 * WIDTH;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_LOAD = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Working registers
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;
    logic [PW-1:0]    r_sh;   // shift value (low word) or MUL multiplicand
    logic [WIDTH-1:0] r_mb;   // MUL multiplier, consumed LSB first
    logic [PW-1:0]    r_acc;  // MUL product accumulator
    logic             r_sc;   // last bit shifted out

    // Output registers
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_carry;
    logic             r_zero;
    logic             r_err;

    logic [CNT_W-1:0] w_cnt_load;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_hi;
    logic             w_carry;
    logic             w_zero;
    logic             w_ill;
    logic             w_last;

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_result_lo = r_lo;
    assign o_result_hi = r_hi;
    assign o_carry     = r_carry;
    assign o_zero      = r_zero;
    assign o_err       = r_err;

    // Final RUN cycle: the counter has run out and results are committed
    assign w_last = (r_cnt == '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Iteration count: shifts clamp to WIDTH, a zero count still takes one cycle
    always_comb begin
        w_cnt_load = CNT_W'(1);
        if (i_op == OP_SHL || i_op == OP_SHR) begin
            if (i_b_in >= WIDTH'(WIDTH)) begin
                w_cnt_load = CNT_W'(WIDTH);
            end else if (i_b_in != '0) begin
                w_cnt_load = CNT_W'(i_b_in);
            end
        end else if (i_op == OP_MUL) begin
            w_cnt_load = CNT_W'(WIDTH);
        end
    end

    assign w_sum = {1'b0, r_a} + {1'b0, r_b};
    assign w_dif = {1'b0, r_a} - {1'b0, r_b};

    // Result selection at commit; illegal ops keep the previous result
    always_comb begin
        w_lo    = r_lo;
        w_hi    = r_hi;
        w_carry = r_carry;
        w_zero  = r_zero;
        w_ill   = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_lo    = w_sum[WIDTH-1:0];
                w_hi    = r_b;
                w_carry = w_sum[WIDTH];
                w_zero  = (w_sum[WIDTH-1:0] == '0);
            end
            OP_SUB: begin
                w_lo    = w_dif[WIDTH-1:0];
                w_hi    = r_b;
                w_carry = w_dif[WIDTH];
                w_zero  = (w_dif[WIDTH-1:0] == '0);
            end
            OP_SHL, OP_SHR: begin
                w_lo    = r_sh[WIDTH-1:0];
                w_hi    = r_b;
                w_carry = r_sc;
                w_zero  = (r_sh[WIDTH-1:0] == '0);
            end
            OP_MUL: begin
                w_lo    = r_acc[WIDTH-1:0];
                w_hi    = r_acc[PW-1:WIDTH];
                w_carry = 1'b0;
                w_zero  = (r_acc == '0);
            end
            OP_LOAD: begin
                w_lo    = r_a;
                w_hi    = r_b;
                w_carry = 1'b0;
                w_zero  = (r_a == '0);
            end
            default: w_ill = 1'b1;
        endcase
    end

    // Datapath: capture, per-cycle iteration, commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_mb    <= '0;
            r_acc   <= '0;
            r_sc    <= 1'b0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_op  <= i_op;
                        r_a   <= i_a_in;
                        r_b   <= i_b_in;
                        r_cnt <= w_cnt_load;
                        r_sh  <= PW'(i_a_in);
                        r_mb  <= i_b_in;
                        r_acc <= '0;
                        r_sc  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!w_last) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        case (r_op)
                            OP_SHL: begin
                                if (r_b != '0) begin
                                    r_sc <= r_sh[WIDTH-1];
                                    r_sh <= PW'({r_sh[WIDTH-2:0], 1'b0});
                                end
                            end
                            OP_SHR: begin
                                if (r_b != '0) begin
                                    r_sc <= r_sh[0];
                                    r_sh <= PW'(r_sh[WIDTH-1:1]);
                                end
                            end
                            OP_MUL: begin
                                if (r_mb[0]) r_acc <= r_acc + r_sh;
                                r_sh <= r_sh << 1;
                                r_mb <= r_mb >> 1;
                            end
                            default: ;
                        endcase
                    end else begin
                        r_lo    <= w_lo;
                        r_hi    <= w_hi;
                        r_carry <= w_carry;
                        r_zero  <= w_zero;
                        r_err   <= w_ill;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status strobes registered from the next state so they align with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_DONE);
        end
    end

endmodule
